// File: rtl/mcp3202_scheduler.sv
// Round scheduler for an MCP3202 SPI engine: every FCLK/FSMPL cycles it converts each CH_MASK channel in turn.
// adc_start is combinational (the cycle the engine is free); chN_dv strobes one cycle after adc_dv.
// Backpressure: waits in START while adc_busy=1; ticks arriving mid-round are dropped and flagged as overrun.
module mcp3202_scheduler #(
    parameter real      FCLK    = 100e6,
    parameter real      FSMPL   = 500,
    parameter bit [1:0] CH_MASK = 2'b01,
    parameter bit       SGL     = 1'b1,
    parameter int       TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_err,
    output logic        adc_start,
    output logic        adc_sgl,
    output logic        adc_odd,
    input  logic        adc_busy,
    input  logic [11:0] adc_data,
    input  logic        adc_dv,
    output logic [11:0] ch0_data,
    output logic [11:0] ch1_data,
    output logic        ch0_dv,
    output logic        ch1_dv,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int TICK_MAX = $rtoi(FCLK / FSMPL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // First channel of a round and the channels left after it.
    localparam logic       FIRST_CH   = CH_MASK[0] ? 1'b0 : 1'b1;
    localparam logic [1:0] FIRST_REST = CH_MASK & ~(2'b01 << FIRST_CH);

    logic [1:0]  state;
    logic [1:0]  pending;
    logic [31:0] tick_cnt;
    logic [31:0] to_cnt;
    logic        tick;
    logic        to_hit;
    logic        next_ch;

    assign tick      = en && (tick_cnt == 32'(TICK_MAX - 1));
    assign to_hit    = (state == S_WAIT) && !adc_dv && (to_cnt == 32'(TIMEOUT - 1));
    assign next_ch   = pending[0] ? 1'b0 : 1'b1;
    assign adc_start = (state == S_START) && en && !adc_busy;
    assign adc_sgl   = SGL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= 2'b00;
            tick_cnt    <= 32'd0;
            to_cnt      <= 32'd0;
            adc_odd     <= 1'b0;
            ch0_data    <= 12'h000;
            ch1_data    <= 12'h000;
            ch0_dv      <= 1'b0;
            ch1_dv      <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ch0_dv <= 1'b0;
            ch1_dv <= 1'b0;

            if (!en || tick) begin
                tick_cnt <= 32'd0;
            end else begin
                tick_cnt <= tick_cnt + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (tick && (CH_MASK != 2'b00)) begin
                        state   <= S_START;
                        adc_odd <= FIRST_CH;
                        pending <= FIRST_REST;
                    end
                end
                S_START: begin
                    if (!en) begin
                        state   <= S_IDLE;
                        pending <= 2'b00;
                    end else if (!adc_busy) begin
                        state  <= S_WAIT;
                        to_cnt <= 32'd0;
                    end
                end
                S_WAIT: begin
                    if (adc_dv) begin
                        if (adc_odd) begin
                            ch1_data <= adc_data;
                            ch1_dv   <= 1'b1;
                        end else begin
                            ch0_data <= adc_data;
                            ch0_dv   <= 1'b1;
                        end
                        if ((pending != 2'b00) && en) begin
                            state   <= S_START;
                            adc_odd <= next_ch;
                            pending <= pending & ~(2'b01 << next_ch);
                        end else begin
                            state   <= S_IDLE;
                            pending <= 2'b00;
                        end
                    end else if (to_hit) begin
                        state   <= S_IDLE;
                        pending <= 2'b00;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    pending <= 2'b00;
                end
            endcase

            // A new error in the same cycle beats a clear request.
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mcp3202_scheduler.sv
// Bench for mcp3202_scheduler: scripted rounds with hand-derived end results, a reset-abandon sequence,
// then randomized traffic, all checked every cycle against a queue-based round model.
module tb_mcp3202_scheduler;
    localparam int TMAX = 100;
    localparam int TO   = 50;

    logic        clk = 1'b0;
    logic        rst_n, en, clr_err, adc_busy, adc_dv;
    logic [11:0] adc_data;
    logic        adc_start, adc_sgl, adc_odd;
    logic [11:0] ch0_data, ch1_data;
    logic        ch0_dv, ch1_dv, overrun, timeout_err;

    always #5 clk = ~clk;

    mcp3202_scheduler #(
        .FCLK(1000), .FSMPL(10), .CH_MASK(2'b11), .SGL(1'b1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
        .adc_start(adc_start), .adc_sgl(adc_sgl), .adc_odd(adc_odd),
        .adc_busy(adc_busy), .adc_data(adc_data), .adc_dv(adc_dv),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .ch0_dv(ch0_dv), .ch1_dv(ch1_dv),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a round is a queue of channels still to convert; tick and timeout are cycle arithmetic.
    int          cyc = 0;
    int          m_base;
    int          m_todo[$];
    bit          m_conv;
    int          m_deadline;
    logic [11:0] m_data[2];
    bit          m_dv[2];
    bit          m_ovr, m_to;

    function automatic void model_reset();
        m_base = cyc + 1;
        m_todo.delete();
        m_conv = 0;
        m_deadline = 0;
        m_data[0] = 12'h000; m_data[1] = 12'h000;
        m_dv[0] = 0; m_dv[1] = 0;
        m_ovr = 0; m_to = 0;
    endfunction

    function automatic bit model_update();
        bit tk, set_o, set_t;
        tk = en && ((cyc - m_base) % TMAX == TMAX - 1);
        set_o = tk && (m_todo.size() != 0);
        set_t = 0;
        m_dv[0] = 0; m_dv[1] = 0;
        if (m_todo.size() == 0) begin
            if (tk) begin
                m_todo.push_back(0);
                m_todo.push_back(1);
            end
        end else if (!m_conv) begin
            if (!en) m_todo.delete();
            else if (!adc_busy) begin
                m_conv = 1;
                m_deadline = cyc + TO;
            end
        end else if (adc_dv) begin
            m_data[m_todo[0]] = adc_data;
            m_dv[m_todo[0]] = 1;
            void'(m_todo.pop_front());
            m_conv = 0;
            if (!en) m_todo.delete();
        end else if (cyc == m_deadline) begin
            set_t = 1;
            m_todo.delete();
            m_conv = 0;
        end
        m_ovr = set_o ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
        m_to  = set_t ? 1'b1 : (clr_err ? 1'b0 : m_to);
        if (!en) m_base = cyc + 1;
        return tk;
    endfunction

    // Behavioural SPI engine.
    int          eng_cnt = 0;
    int          eng_dly = 20;
    logic [11:0] eng_d0, eng_d1, eng_data;
    int          busy_hold = 0;
    int          row_busy = 0;
    bit          rnd = 0;
    int          nstarts = 0;
    int          nchdv = 0;

    task automatic step(input bit e, input bit c, input bit r);
        bit e_start, tk;
        @(negedge clk);
        en = e; clr_err = c; rst_n = r;
        adc_dv = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) adc_dv = 1'b1;
        end
        adc_data = adc_dv ? eng_data : 12'($urandom);
        adc_busy = rnd ? ($urandom_range(0, 7) == 0) : (busy_hold > 0);
        if (busy_hold > 0) busy_hold--;
        #1;
        if (!rst_n) model_reset();
        e_start = rst_n && (m_todo.size() != 0) && !m_conv && en && !adc_busy;
        chk("adc_start", 32'(adc_start), 32'(e_start));
        chk("adc_sgl", 32'(adc_sgl), 32'd1);
        if (m_todo.size() != 0) chk("adc_odd", 32'(adc_odd), 32'(m_todo[0]));
        chk("ch0_data", 32'(ch0_data), 32'(m_data[0]));
        chk("ch1_data", 32'(ch1_data), 32'(m_data[1]));
        chk("ch0_dv", 32'(ch0_dv), 32'(m_dv[0]));
        chk("ch1_dv", 32'(ch1_dv), 32'(m_dv[1]));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        nchdv += int'(ch0_dv) + int'(ch1_dv);
        if (adc_start) begin
            nstarts++;
            if (rnd) begin
                eng_dly = $urandom_range(5, 60);
                eng_d0 = 12'($urandom);
                eng_d1 = 12'($urandom);
            end
            eng_data = adc_odd ? eng_d1 : eng_d0;
            if (eng_dly > 0) eng_cnt = eng_dly;
        end
        if (rst_n) begin
            tk = model_update();
            if (tk && row_busy > 0) busy_hold = row_busy;
        end
        cyc++;
    endtask

    typedef struct {
        int          cycles;
        bit          en;
        int          off;
        bit          clr;
        int          busy;
        int          dly;
        logic [11:0] d0, d1;
        logic [11:0] x0, x1;
        bit          xovr, xto;
        int          xstarts;
    } row_t;

    row_t tbl[8];

    initial begin
        tbl[0] = '{5,   0, -1, 0, 0, 20, 12'h000, 12'h000, 12'h000, 12'h000, 0, 0, 0};
        tbl[1] = '{250, 1, -1, 0, 0, 20, 12'hABC, 12'h123, 12'hABC, 12'h123, 0, 0, 4};
        tbl[2] = '{200, 1, -1, 0, 7, 20, 12'h555, 12'hAAA, 12'h555, 12'hAAA, 0, 0, 4};
        tbl[3] = '{230, 1, -1, 0, 0, 0,  12'hFFF, 12'hFFF, 12'h555, 12'hAAA, 0, 1, 2};
        tbl[4] = '{200, 1, -1, 1, 0, 20, 12'h111, 12'h222, 12'h111, 12'h222, 0, 0, 4};
        tbl[5] = '{250, 1, -1, 0, 0, 49, 12'h7E7, 12'h181, 12'h7E7, 12'h181, 1, 0, 3};
        tbl[6] = '{30,  0, -1, 1, 0, 20, 12'h000, 12'h000, 12'h7E7, 12'h181, 0, 0, 0};
        tbl[7] = '{200, 1, 110, 0, 0, 20, 12'h3C3, 12'hC3C, 12'h3C3, 12'h181, 0, 0, 1};

        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
        adc_busy = 1'b0; adc_dv = 1'b0; adc_data = 12'h000;
        eng_d0 = 12'h000; eng_d1 = 12'h000; eng_data = 12'h000;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            eng_dly = tbl[r].dly;
            eng_d0 = tbl[r].d0;
            eng_d1 = tbl[r].d1;
            row_busy = tbl[r].busy;
            nstarts = 0;
            for (int c = 0; c < tbl[r].cycles; c++)
                step(tbl[r].en && (tbl[r].off < 0 || c < tbl[r].off), tbl[r].clr && (c == 0), 1'b1);
            chk($sformatf("row%0d ch0_data", r), 32'(ch0_data), 32'(tbl[r].x0));
            chk($sformatf("row%0d ch1_data", r), 32'(ch1_data), 32'(tbl[r].x1));
            chk($sformatf("row%0d overrun", r), 32'(overrun), 32'(tbl[r].xovr));
            chk($sformatf("row%0d timeout_err", r), 32'(timeout_err), 32'(tbl[r].xto));
            chk($sformatf("row%0d starts", r), 32'(nstarts), 32'(tbl[r].xstarts));
        end

        // Reset in the middle of a ch0 conversion; the engine still answers afterwards.
        row_busy = 0;
        eng_dly = 20;
        eng_d0 = 12'h5A5;
        eng_d1 = 12'hA5A;
        for (int c = 0; c < 105; c++) step(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0);
        nchdv = 0;
        nstarts = 0;
        for (int c = 0; c < 25; c++) step(1'b0, 1'b0, 1'b1);
        chk("rst ch0_data", 32'(ch0_data), 32'h000);
        chk("rst ch1_data", 32'(ch1_data), 32'h000);
        chk("rst chN_dv strobes", 32'(nchdv), 32'd0);
        chk("rst starts", 32'(nstarts), 32'd0);
        chk("rst adc_odd", 32'(adc_odd), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);

        // Randomized traffic: engine delays straddle the timeout, busy and en toggle freely.
        rnd = 1;
        begin
            bit en_r;
            en_r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) en_r = !en_r;
                step(en_r, $urandom_range(0, 49) == 0, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mcp3202_scheduler.md
MCP3202_SCHEDULER -- requirements
Module: mcp3202_scheduler

Interface
REQ-001 SHALL have parameter FCLK, default 100e6, input clock frequency in Hz.
REQ-002 SHALL have parameter FSMPL, default 500, sample rounds per second.
REQ-003 SHALL have parameter CH_MASK, default 2'b01; bit n=1 enables channel n in each round.
REQ-004 SHALL have parameter SGL, default 1; 1=single-ended, 0=differential (channel bit selects polarity).
REQ-005 SHALL have parameter TIMEOUT, default 20000, max clk cycles from adc_start to adc_dv.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  1=schedule rounds, 0=stop issuing new conversions.
REQ-009 clr_err  in  1  clears overrun and timeout_err.
REQ-010 adc_start  out  1  one-cycle conversion request to SPI engine.
REQ-011 adc_sgl  out  1  mode to SPI engine, constant = SGL.
REQ-012 adc_odd  out  1  channel select to SPI engine, held from adc_start until adc_dv.
REQ-013 adc_busy  in  1  SPI engine transaction in progress.
REQ-014 adc_data  in  12  conversion result, valid with adc_dv.
REQ-015 adc_dv  in  1  one-cycle result strobe.
REQ-016 ch0_data / ch1_data  out  12  last result per channel.
REQ-017 ch0_dv / ch1_dv  out  1  one-cycle new-result strobe per channel.
REQ-018 overrun  out  1  sticky: tick arrived during an active round.
REQ-019 timeout_err  out  1  sticky: adc_dv missing after TIMEOUT cycles.

Function
REQ-020 Tick counter SHALL count 0..TICK_MAX-1, TICK_MAX=FCLK/FSMPL (integer), wrap to 0, tick = (count==TICK_MAX-1) while en=1.
REQ-021 en=0 SHALL hold tick counter at 0; en rising restarts the full TICK_MAX period.
REQ-022 FSM states: IDLE, START, WAIT; reset state IDLE.
REQ-023 IDLE: on tick with CH_MASK!=0 -> START, channel = lowest enabled bit, pending = remaining enabled bits.
REQ-024 START: while adc_busy=1 stay; when adc_busy=0 pulse adc_start one cycle, drive adc_odd=channel, -> WAIT.
REQ-025 WAIT: on adc_dv capture adc_data into chN_data, pulse chN_dv on following cycle.
REQ-026 WAIT exit on adc_dv: pending!=0 and en=1 -> START with next channel; else -> IDLE.
REQ-027 Latency: adc_start SHALL assert the cycle after tick when adc_busy=0; chN_dv SHALL assert one cycle after adc_dv.
REQ-028 Timeout counter SHALL clear on entry to WAIT, count each WAIT cycle; reaching TIMEOUT sets timeout_err, -> IDLE, pending cleared, no chN_dv.
REQ-029 Tick while state!=IDLE SHALL set overrun and be dropped (no queued round).
REQ-030 adc_dv outside WAIT SHALL be ignored (no capture, no strobe).
REQ-031 en=0 mid-round: current WAIT completes normally, no further adc_start issued, -> IDLE; en=0 in START -> IDLE without adc_start.
REQ-032 clr_err SHALL clear both sticky flags next cycle; same-cycle set condition wins over clear.
REQ-033 CH_MASK=0: FSM SHALL stay in IDLE, no adc_start.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state IDLE, tick/timeout counters 0, adc_start 0, adc_odd 0, chN_data 12'h000, chN_dv 0, overrun 0, timeout_err 0; adc_sgl = SGL.
REQ-035 Reset mid-WAIT SHALL abandon the conversion; a late adc_dv after release SHALL be ignored.

Verification (FCLK=1000, FSMPL=10 -> TICK_MAX=100, TIMEOUT=50)
REQ-036 CH_MASK=2'b11, en=1, engine returns 12'hABC (ch0) then 12'h123 (ch1) 20 cycles after each start -> ch0_data=ABC with ch0_dv, then adc_odd=1 start, ch1_data=123 with ch1_dv, every 100 cycles.
REQ-037 adc_busy held 1 for 7 cycles after tick -> adc_start delayed exactly until first cycle after adc_busy falls.
REQ-038 engine never returns adc_dv -> timeout_err=1 at cycle 50 of WAIT, FSM IDLE, next tick starts new round; clr_err -> 0.
REQ-039 engine responds in 120 cycles (TIMEOUT=200) -> overrun=1, no extra adc_start for dropped tick.
REQ-040 en=0 asserted during ch0 WAIT with CH_MASK=2'b11 -> ch0 result delivered, no ch1 adc_start, FSM IDLE, tick counter 0.
REQ-041 rst_n pulsed low mid-WAIT, stray adc_dv after release -> all outputs at reset values, no chN_dv.
